// File: rtl/regbank_writeback.sv
// Write-side front end for the register bank: accepts ALU and load writeback
// requests, queues them in order, and drives the bank's single write port.
// A per-register pending counter lets decode stall on RAW hazards.
module regbank_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              hold,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] query_reg1,
  input  logic [ADDR_W-1:0] query_reg2,
  output logic              busy1,
  output logic              busy2,
  output logic              empty,
  output logic              bad_reg
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PEND_W = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] XZR_IDX = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] LIM_IDX = ADDR_W'(NREGS);

  logic [ADDR_W-1:0] fifo_reg_q  [DEPTH];
  logic [ADDR_W-1:0] fifo_reg_d  [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PEND_W-1:0] pending_q [NREGS];
  logic [PEND_W-1:0] pending_d [NREGS];
  logic              bad_reg_q, bad_reg_d;

  logic [CNT_W-1:0]  free;
  logic              mem_fire, alu_fire;
  logic              mem_keep, alu_keep;
  logic              mem_bad, alu_bad;
  logic              e0_v, e1_v;
  logic [ADDR_W-1:0] e0_reg, e1_reg;
  logic [DATA_W-1:0] e0_data, e1_data;
  logic              deq;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;

  // Ready from registered occupancy; the load path gets priority on the last slot
  always_comb begin
    free      = CNT_W'(DEPTH) - count_q;
    mem_ready = !reset && (free != '0);
    alu_ready = !reset && ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !mem_valid));
  end

  // Classify accepted requests: keep normal indices, swallow XZR, flag out-of-range
  always_comb begin
    mem_fire = mem_valid && mem_ready;
    alu_fire = alu_valid && alu_ready;
    mem_keep = mem_fire && (mem_reg < XZR_IDX);
    alu_keep = alu_fire && (alu_reg < XZR_IDX);
    mem_bad  = mem_fire && (mem_reg >= LIM_IDX);
    alu_bad  = alu_fire && (alu_reg >= LIM_IDX);
  end

  // Pack kept requests into up to two enqueue slots, load entry first (it is older)
  always_comb begin
    e0_v    = 1'b0;
    e0_reg  = '0;
    e0_data = '0;
    e1_v    = 1'b0;
    e1_reg  = '0;
    e1_data = '0;
    if (mem_keep) begin
      e0_v    = 1'b1;
      e0_reg  = mem_reg;
      e0_data = mem_data;
      e1_v    = alu_keep;
      e1_reg  = alu_reg;
      e1_data = alu_data;
    end else begin
      e0_v    = alu_keep;
      e0_reg  = alu_reg;
      e0_data = alu_data;
    end
  end

  // Bank write port: head of queue, zeros when nothing is queued
  always_comb begin
    empty     = (count_q == '0);
    head_reg  = fifo_reg_q[rd_ptr_q];
    head_data = fifo_data_q[rd_ptr_q];
    reg_write = !reset && !empty && !hold;
    deq       = reg_write;
    write_reg  = empty ? '0 : head_reg;
    write_data = empty ? '0 : head_data;
  end

  // FIFO storage, pointers and occupancy next-state
  always_comb begin
    fifo_reg_d  = fifo_reg_q;
    fifo_data_d = fifo_data_q;
    if (e0_v) begin
      fifo_reg_d[wr_ptr_q]  = e0_reg;
      fifo_data_d[wr_ptr_q] = e0_data;
    end
    if (e1_v) begin
      fifo_reg_d[wr_ptr_q + PTR_W'(1)]  = e1_reg;
      fifo_data_d[wr_ptr_q + PTR_W'(1)] = e1_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(e0_v) + PTR_W'(e1_v);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    count_d  = count_q + CNT_W'(e0_v) + CNT_W'(e1_v) - CNT_W'(deq);
  end

  // Pending-write scoreboard: +1 per enqueue, -1 per dequeue of the same register
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      pending_d[r] = pending_q[r]
                   + PEND_W'(e0_v && (e0_reg == ADDR_W'(r)))
                   + PEND_W'(e1_v && (e1_reg == ADDR_W'(r)))
                   - PEND_W'(deq && (head_reg == ADDR_W'(r)));
    end
    bad_reg_d = bad_reg_q || mem_bad || alu_bad;
  end

  // Hazard queries; XZR and out-of-range indices never report busy
  always_comb begin
    busy1 = (query_reg1 < XZR_IDX) && (pending_q[query_reg1[IDX_W-1:0]] != '0);
    busy2 = (query_reg2 < XZR_IDX) && (pending_q[query_reg2[IDX_W-1:0]] != '0);
    bad_reg = bad_reg_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_reg_q  <= '{default: '0};
      fifo_data_q <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= '{default: '0};
      bad_reg_q   <= 1'b0;
    end else begin
      fifo_reg_q  <= fifo_reg_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      bad_reg_q   <= bad_reg_d;
    end
  end

endmodule

// File: tb/tb_regbank_writeback.sv
// Bench for regbank_writeback: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_regbank_writeback;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 6;
  localparam int NREGS  = 32;

  logic              clk;
  logic              reset;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              hold;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] query_reg1, query_reg2;
  logic              busy1, busy2, empty, bad_reg;

  regbank_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .hold(hold), .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .query_reg1(query_reg1), .query_reg2(query_reg2),
    .busy1(busy1), .busy2(busy2), .empty(empty), .bad_reg(bad_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t mq[$];
  logic mbad;
  int   tests;
  int   fails;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic mbusy(input logic [ADDR_W-1:0] q);
    if (q >= ADDR_W'(NREGS - 1)) return 1'b0;
    foreach (mq[i]) if (mq[i].r == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mpush(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    ent_t e;
    if (r >= ADDR_W'(NREGS)) mbad = 1'b1;
    else if (r != ADDR_W'(NREGS - 1)) begin
      e.r = r;
      e.d = d;
      mq.push_back(e);
    end
  endtask

  // Drive inputs just after the falling edge, then let them settle
  task automatic drive(input logic rst, input logic av, input logic [ADDR_W-1:0] ar,
                       input logic [DATA_W-1:0] ad, input logic mv, input logic [ADDR_W-1:0] mr,
                       input logic [DATA_W-1:0] md, input logic h,
                       input logic [ADDR_W-1:0] q1, input logic [ADDR_W-1:0] q2);
    reset = rst; alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md; hold = h;
    query_reg1 = q1; query_reg2 = q2;
    #1;
  endtask

  task automatic idle(input logic h, input logic [ADDR_W-1:0] q1, input logic [ADDR_W-1:0] q2);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, h, q1, q2);
  endtask

  // Compare every output against the model, then advance the model over one edge
  task automatic step();
    int   free;
    logic e_mr, e_ar, e_rw, m_acc, a_acc;
    ent_t head;
    free = DEPTH - mq.size();
    e_mr = !reset && (free >= 1);
    e_ar = !reset && ((free >= 2) || ((free == 1) && !mem_valid));
    e_rw = !reset && (mq.size() != 0) && !hold;
    head = '0;
    if (mq.size() != 0) head = mq[0];
    chk("mem_ready",  mem_ready,  e_mr);
    chk("alu_ready",  alu_ready,  e_ar);
    chk("reg_write",  reg_write,  e_rw);
    chk("write_reg",  write_reg,  head.r);
    chk("write_data", write_data, head.d);
    chk("empty",      empty,      mq.size() == 0);
    chk("busy1",      busy1,      mbusy(query_reg1));
    chk("busy2",      busy2,      mbusy(query_reg2));
    chk("bad_reg",    bad_reg,    mbad);
    m_acc = mem_valid && e_mr;
    a_acc = alu_valid && e_ar;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      mbad = 1'b0;
    end else begin
      if (e_rw) mq.delete(0);
      if (m_acc) mpush(mem_reg, mem_data);
      if (a_acc) mpush(alu_reg, alu_data);
    end
    @(negedge clk);
  endtask

  function automatic logic [ADDR_W-1:0] rnd_reg();
    int unsigned v;
    v = $urandom_range(0, 99);
    if (v < 80) return ADDR_W'($urandom_range(0, 7));
    if (v < 88) return ADDR_W'(31);
    if (v < 92) return ADDR_W'($urandom_range(32, 63));
    return ADDR_W'($urandom_range(8, 30));
  endfunction

  logic [ADDR_W-1:0] order3 [4];

  initial begin
    tests = 0;
    fails = 0;
    mbad  = 1'b0;
    reset = 1'b1; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0; hold = 1'b0;
    query_reg1 = '0; query_reg2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    idle(1'b0, 6'd5, 6'd0);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_busy", {busy1, busy2}, 2'b00);
    chk("rst_bad", bad_reg, 1'b0);
    step();

    // 1: single ALU write, one-cycle latency
    drive(1'b0, 1'b1, 6'd5, 64'hDEAD, 1'b0, '0, '0, 1'b0, 6'd5, 6'd0);
    chk("s1_alu_ready", alu_ready, 1'b1);
    step();
    idle(1'b0, 6'd5, 6'd0);
    chk("s1_reg_write", reg_write, 1'b1);
    chk("s1_write_reg", write_reg, 5);
    chk("s1_write_data", write_data, 64'hDEAD);
    chk("s1_busy_set", busy1, 1'b1);
    step();
    idle(1'b0, 6'd5, 6'd0);
    chk("s1_busy_clr", busy1, 1'b0);
    chk("s1_empty", empty, 1'b1);
    step();

    // 2: simultaneous ALU and load, load issues first
    drive(1'b0, 1'b1, 6'd3, 64'h33, 1'b1, 6'd4, 64'h44, 1'b0, 6'd3, 6'd4);
    step();
    idle(1'b0, 6'd3, 6'd4);
    chk("s2_first_reg", write_reg, 4);
    chk("s2_first_data", write_data, 64'h44);
    step();
    idle(1'b0, 6'd3, 6'd4);
    chk("s2_second_reg", write_reg, 3);
    chk("s2_second_rw", reg_write, 1'b1);
    step();

    // 3: fill under hold, then drain in acceptance order
    drive(1'b0, 1'b1, 6'd10, 64'hA0, 1'b1, 6'd11, 64'hB0, 1'b1, 6'd10, 6'd13);
    step();
    drive(1'b0, 1'b1, 6'd12, 64'hA1, 1'b1, 6'd13, 64'hB1, 1'b1, 6'd10, 6'd13);
    step();
    drive(1'b0, 1'b1, 6'd14, 64'hA2, 1'b1, 6'd15, 64'hB2, 1'b1, 6'd14, 6'd15);
    chk("s3_alu_ready_full", alu_ready, 1'b0);
    chk("s3_mem_ready_full", mem_ready, 1'b0);
    chk("s3_hold_no_write", reg_write, 1'b0);
    step();
    order3[0] = 6'd11; order3[1] = 6'd10; order3[2] = 6'd13; order3[3] = 6'd12;
    for (int k = 0; k < 4; k++) begin
      idle(1'b0, 6'd10, 6'd13);
      chk("s3_order", write_reg, order3[k]);
      step();
    end
    idle(1'b0, 6'd14, 6'd15);
    chk("s3_drained", empty, 1'b1);
    step();

    // 4: XZR and out-of-range indices
    drive(1'b0, 1'b1, 6'd31, 64'h1, 1'b1, 6'd40, 64'h2, 1'b0, 6'd31, 6'd40);
    step();
    idle(1'b0, 6'd31, 6'd40);
    chk("s4_no_write", reg_write, 1'b0);
    chk("s4_busy", {busy1, busy2}, 2'b00);
    chk("s4_bad_set", bad_reg, 1'b1);
    step();
    repeat (3) begin
      idle(1'b0, 6'd0, 6'd0);
      step();
    end
    idle(1'b0, 6'd0, 6'd0);
    chk("s4_bad_sticky", bad_reg, 1'b1);
    step();

    // 5: two queued writes to the same register
    drive(1'b0, 1'b1, 6'd7, 64'h1, 1'b0, '0, '0, 1'b1, 6'd7, 6'd0);
    step();
    drive(1'b0, 1'b1, 6'd7, 64'h2, 1'b0, '0, '0, 1'b1, 6'd7, 6'd0);
    step();
    idle(1'b0, 6'd7, 6'd0);
    chk("s5_busy_first", busy1, 1'b1);
    chk("s5_first_data", write_data, 64'h1);
    step();
    idle(1'b0, 6'd7, 6'd0);
    chk("s5_busy_second", busy1, 1'b1);
    chk("s5_last_data", write_data, 64'h2);
    step();
    idle(1'b0, 6'd7, 6'd0);
    chk("s5_busy_clr", busy1, 1'b0);
    step();

    // 6: reset with three entries queued
    drive(1'b0, 1'b1, 6'd1, 64'h11, 1'b1, 6'd2, 64'h22, 1'b1, 6'd1, 6'd3);
    step();
    drive(1'b0, 1'b1, 6'd3, 64'h33, 1'b0, '0, '0, 1'b1, 6'd1, 6'd3);
    step();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 6'd1, 6'd3);
    chk("s6_rst_no_write", reg_write, 1'b0);
    step();
    idle(1'b0, 6'd1, 6'd3);
    chk("s6_after_no_write", reg_write, 1'b0);
    chk("s6_empty", empty, 1'b1);
    chk("s6_busy", {busy1, busy2}, 2'b00);
    chk("s6_bad_clr", bad_reg, 1'b0);
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 2,
            $urandom_range(0, 9) < 6, rnd_reg(), {$urandom, $urandom},
            $urandom_range(0, 9) < 6, rnd_reg(), {$urandom, $urandom},
            $urandom_range(0, 3) == 0, rnd_reg(), rnd_reg());
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
